// File: rtl/modulo_counter.sv
// Free-running modulo-M up-counter with a combinational carry-out on the last count.
// Typical use is as a frame or word-boundary timebase, e.g. M=32 on an ADC bit clock.
module modulo_counter #(
  parameter int unsigned M = 32,
  localparam int unsigned W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         co,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  logic at_last;

  // Wrap is an explicit compare so non-power-of-two moduli never reach M..2^W-1.
  assign at_last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

  // Carry is unregistered so consumers can sample it on the same edge that wraps cnt.
  assign co = rst_n & en & at_last;

endmodule

// File: tb/tb_modulo_counter.sv
// Directed self-checking bench for modulo_counter at M=32, M=10 and M=1.
module tb_modulo_counter;

  logic       clk = 1'b0;
  logic       rst_a, en_a, co_a;
  logic [4:0] cnt_a;
  logic       rst_b, en_b, co_b;
  logic [3:0] cnt_b;
  logic       rst_c, en_c, co_c;
  logic [0:0] cnt_c;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic rst_n;
    logic en;
    logic cnt;
    logic co;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  modulo_counter #(.M(32)) u_a (.clk(clk), .rst_n(rst_a), .en(en_a), .co(co_a), .cnt(cnt_a));
  modulo_counter #(.M(10)) u_b (.clk(clk), .rst_n(rst_b), .en(en_b), .co(co_b), .cnt(cnt_b));
  modulo_counter #(.M(1))  u_c (.clk(clk), .rst_n(rst_c), .en(en_c), .co(co_c), .cnt(cnt_c));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;

    // M=1: cnt fixed at 0, co mirrors en only while out of reset.
    vecs[0] = '{rst_n: 1'b0, en: 1'b1, cnt: 1'b0, co: 1'b0};
    vecs[1] = '{rst_n: 1'b0, en: 1'b0, cnt: 1'b0, co: 1'b0};
    vecs[2] = '{rst_n: 1'b1, en: 1'b1, cnt: 1'b0, co: 1'b1};
    vecs[3] = '{rst_n: 1'b1, en: 1'b0, cnt: 1'b0, co: 1'b0};
    vecs[4] = '{rst_n: 1'b1, en: 1'b1, cnt: 1'b0, co: 1'b1};
    vecs[5] = '{rst_n: 1'b1, en: 1'b1, cnt: 1'b0, co: 1'b1};
    vecs[6] = '{rst_n: 1'b0, en: 1'b1, cnt: 1'b0, co: 1'b0};
    vecs[7] = '{rst_n: 1'b1, en: 1'b1, cnt: 1'b0, co: 1'b1};

    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;

    // M=32 reset held for 3 cycles with en high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_rst_cnt", int'(cnt_a), 0);
      check("a_rst_co", int'(co_a), 0);
    end
    rst_a = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      check("a_run_cnt", int'(cnt_a), i % 32);
      check("a_run_co", int'(co_a), (i % 32 == 31) ? 1 : 0);
      tick();
    end

    // enable hold at cnt=7
    for (int i = 0; i < 3; i++) tick();
    check("a_hold_pre", int'(cnt_a), 7);
    en_a = 1'b0;
    #1;
    check("a_hold_co0", int'(co_a), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_hold_cnt", int'(cnt_a), 7);
      check("a_hold_co", int'(co_a), 0);
    end
    en_a = 1'b1;
    tick();
    check("a_resume", int'(cnt_a), 8);
    for (int k = 9; k <= 31; k++) begin
      check("a_resume_co0", int'(co_a), 0);
      tick();
      check("a_resume_cnt", int'(cnt_a), k);
    end
    check("a_resume_co", int'(co_a), 1);

    // enable dropped at terminal count
    en_a = 1'b0;
    #1;
    check("a_term_co_drop", int'(co_a), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("a_term_cnt", int'(cnt_a), 31);
      check("a_term_co", int'(co_a), 0);
    end
    en_a = 1'b1;
    #1;
    check("a_term_co_back", int'(co_a), 1);
    tick();
    check("a_term_wrap", int'(cnt_a), 0);
    check("a_term_wrap_co", int'(co_a), 0);

    // mid-period reset at cnt=20
    for (int i = 0; i < 20; i++) tick();
    check("a_mid_pre", int'(cnt_a), 20);
    rst_a = 1'b0;
    #1;
    check("a_mid_co_rst", int'(co_a), 0);
    tick();
    check("a_mid_cnt", int'(cnt_a), 0);
    check("a_mid_co", int'(co_a), 0);
    rst_a = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      check("a_post_cnt", int'(cnt_a), k);
      check("a_post_co", int'(co_a), (k == 31) ? 1 : 0);
      tick();
    end

    // reset asserted at cnt=31 must mask co
    for (int i = 0; i < 31; i++) tick();
    check("a_rst31_pre", int'(cnt_a), 31);
    rst_a = 1'b0;
    #1;
    check("a_rst31_co", int'(co_a), 0);
    tick();
    check("a_rst31_cnt", int'(cnt_a), 0);
    rst_a = 1'b1;

    // M=10 wrap without binary overflow
    rst_b = 1'b0; en_b = 1'b1;
    tick();
    check("b_rst_cnt", int'(cnt_b), 0);
    check("b_rst_co", int'(co_b), 0);
    rst_b = 1'b1;
    #1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      check("b_cnt", int'(cnt_b), i % 10);
      check("b_co", int'(co_b), (i % 10 == 9) ? 1 : 0);
      if (i < 20 && co_b) pulses++;
      tick();
    end
    check("b_pulses20", pulses, 2);

    // M=1 table
    for (int i = 0; i < 8; i++) begin
      rst_c = vecs[i].rst_n;
      en_c  = vecs[i].en;
      #1;
      check($sformatf("c_cnt[%0d]", i), int'(cnt_c), int'(vecs[i].cnt));
      check($sformatf("c_co[%0d]", i), int'(co_c), int'(vecs[i].co));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modulo_counter.md
# modulo_counter

Free-running modulo-M up-counter with a carry-out. The block counts enabled clock cycles from 0 to M-1, wraps to 0, and raises `co` for the last count of every period. Typical use is as a frame or word-boundary timebase. In the ADC serial-interface model it runs on the bit clock with M=32 and marks every 32nd bit for the frame-sync and shift-register load logic. This is the `counter` module and keeps that positional port order.

## Interface
Parameters:
- `M`, default 32: modulus, meaning the number of counts per period. Legal range is M ≥ 1.

Ports, in positional order:
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `en`  input  1  count enable.
- `co`  output  1  carry-out; high during the final count (M-1) of each period while enabled.
- `cnt`  output  W  current count value. This port is optional and may be left unconnected.

Width rule: W = $clog2(M) when M > 1, and W = 1 when M = 1.

## Operation
- State is a single register `cnt` of width W.
- Reset: on a rising `clk` edge with `rst_n`=0, `cnt` is set to 0. Reset has priority over `en`.
- Counting: on a rising edge with `rst_n`=1 and `en`=1:
  - if `cnt` == M-1, then `cnt` is set to 0;
  - otherwise `cnt` is set to `cnt`+1.
- Hold: with `rst_n`=1 and `en`=0, `cnt` keeps its value.
- Wrap is an explicit compare against M-1. It must not rely on natural binary overflow, so non-power-of-two M works correctly; for example M=10 gives 0..9.
- Carry-out is combinational, with no register: `co` = `rst_n` & `en` & (`cnt` == M-1).
- M=1 case: `cnt` stays at 0 and `co` = `rst_n` & `en`.
- `cnt` never holds a value ≥ M after reset has been applied.
- Simultaneous `rst_n`=0 and `en`=1: the counter resets and `co`=0.
- Reset asserted mid-period: the next edge gives `cnt`=0. After release, the first `co` comes M-1 enabled edges later.
- No internal state other than `cnt`. No clock gating, and no asynchronous paths besides the combinational `co`.

## Timing
- Reset values: `cnt`=0, and `co`=0 while `rst_n`=0.
- Period: with `en` held high, `co` is high for exactly 1 cycle out of every M. It is high in the cycle where `cnt`=M-1, and the edge that ends that cycle wraps `cnt` to 0.
- Latency from reset release:
  - with `en`=1 continuously, `co` first goes high in the cycle after the (M-1)th rising edge following release;
  - for M=32, `co` first goes high after 31 edges.
- `co` is valid combinationally within the same cycle. Consumers sample it on the same rising edge that wraps the counter, or on the following falling edge in half-cycle designs.
- Enable gating: deasserting `en` while `cnt`=M-1 drops `co` immediately and freezes `cnt` at M-1. Reasserting `en` raises `co` again in that same cycle, and the next edge wraps to 0.
- Each rising edge with `en`=1 advances the count by one. There are no multi-cycle paths.

## Test plan
- Reset then count, M=32, `en`=1: hold `rst_n`=0 for 3 cycles, then release.
  - Required: `cnt` steps 0,1,…,31,0.
  - `co` is high only in the cycles where `cnt`=31, i.e. 1 of 32 cycles, repeating for at least 3 periods.
- Enable hold, M=32: drop `en` for 5 cycles at `cnt`=7.
  - Required: `cnt` stays 7, and `co`=0 throughout.
  - After re-enable, counting resumes at 8 and the next `co` comes 24 edges later.
- Enable at terminal count, M=32: drop `en` at `cnt`=31.
  - Required: `co` falls in the same cycle and `cnt` holds 31.
  - Re-enable: `co`=1 immediately, then `cnt`=0 on the next edge.
- Mid-period reset, M=32: assert `rst_n`=0 for 1 cycle at `cnt`=20 with `en`=1.
  - Required: `cnt`=0 after the edge, and `co` stays 0.
  - The next `co` occurs at `cnt`=31, i.e. 31 edges after release.
- Non-power-of-two modulus, M=10: run 25 enabled cycles after reset.
  - Required: `cnt` sequence 0..9 repeating, never reaching 10–15.
  - `co` high at cycles where `cnt`=9, i.e. exactly 2 pulses in the first 20 cycles.
- Degenerate modulus, M=1: toggle `en` as 1,0,1,1.
  - Required: `cnt` always 0 and `co` follows `en` exactly.
  - During reset, `co`=0 regardless of `en`.
